// File: rtl/div_error_monitor.sv
// div_error_monitor
// Error-statistics monitor for a 16/8 approximate array divider. Each
// accepted sample (x, y, q_app, r_app) is re-divided exactly with an 8-step
// restoring divider. The exact result is then compared against the
// approximate one. Per-window totals are published once every WIN samples.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   stat_clr   synchronous clear of accumulators and any in-flight sample
//   in_valid   sample present
//   in_ready   monitor idle, can accept a sample
//   x, y       dividend (16b), divisor (8b)
//   q_app      approximate quotient (8b)
//   r_app      approximate remainder (8b)
//   rpt_valid  one-cycle pulse, report outputs just updated
//   err_cnt    samples whose quotient or remainder mismatched
//   skip_cnt   samples not comparable (y==0 or quotient overflow)
//   sum_ed     saturating sum of |q_app - q_ex|
//   max_ed     maximum |q_app - q_ex|
module div_error_monitor #(
   parameter int unsigned WIN   = 256,
   parameter int unsigned ACC_W = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stat_clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      x,
   input  logic [7:0]       y,
   input  logic [7:0]       q_app,
   input  logic [7:0]       r_app,
   output logic             rpt_valid,
   output logic [15:0]      err_cnt,
   output logic [15:0]      skip_cnt,
   output logic [ACC_W-1:0] sum_ed,
   output logic [7:0]       max_ed
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DIV  = 2'd1;
   localparam logic [1:0] S_CMP  = 2'd2;

   localparam logic [15:0] WIN_W = WIN[15:0];

   logic [1:0]       state_q, state_d;
   logic [7:0]       x_lo_q, x_lo_d;      // only the low byte is shifted in during DIV
   logic [7:0]       y_q, y_d;
   logic [7:0]       q_app_q, q_app_d;
   logic [7:0]       r_app_q, r_app_d;
   logic [8:0]       p_q, p_d;
   logic [7:0]       q_ex_q, q_ex_d;
   logic [2:0]       step_q, step_d;
   logic             skip_q, skip_d;
   logic [15:0]      idx_q, idx_d;
   logic [15:0]      err_acc_q, err_acc_d;
   logic [15:0]      skip_acc_q, skip_acc_d;
   logic [ACC_W-1:0] sum_acc_q, sum_acc_d;
   logic [7:0]       max_acc_q, max_acc_d;
   logic             rpt_valid_q, rpt_valid_d;
   logic [15:0]      err_cnt_q, err_cnt_d;
   logic [15:0]      skip_cnt_q, skip_cnt_d;
   logic [ACC_W-1:0] sum_ed_q, sum_ed_d;
   logic [7:0]       max_ed_q, max_ed_d;

   // Datapath helpers
   logic [8:0]       p_shift;
   logic [7:0]       ed;
   logic [ACC_W:0]   sum_ext;
   logic [15:0]      idx_inc;

   assign p_shift = {p_q[7:0], x_lo_q[step_q]};
   assign ed      = (q_app_q >= q_ex_q) ? (q_app_q - q_ex_q) : (q_ex_q - q_app_q);
   assign sum_ext = {1'b0, sum_acc_q} + {{(ACC_W-7){1'b0}}, ed};
   assign idx_inc = idx_q + 16'd1;

   always_comb begin
      state_d     = state_q;
      x_lo_d      = x_lo_q;
      y_d         = y_q;
      q_app_d     = q_app_q;
      r_app_d     = r_app_q;
      p_d         = p_q;
      q_ex_d      = q_ex_q;
      step_d      = step_q;
      skip_d      = skip_q;
      idx_d       = idx_q;
      err_acc_d   = err_acc_q;
      skip_acc_d  = skip_acc_q;
      sum_acc_d   = sum_acc_q;
      max_acc_d   = max_acc_q;
      rpt_valid_d = 1'b0;
      err_cnt_d   = err_cnt_q;
      skip_cnt_d  = skip_cnt_q;
      sum_ed_d    = sum_ed_q;
      max_ed_d    = max_ed_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               x_lo_d  = x[7:0];
               y_d     = y;
               q_app_d = q_app;
               r_app_d = r_app;
               p_d     = {1'b0, x[15:8]};
               q_ex_d  = 8'd0;
               step_d  = 3'd7;
               // A high byte >= y means the true quotient needs more than 8 bits.
               skip_d  = (y == 8'd0) || (x[15:8] >= y);
               state_d = ((y == 8'd0) || (x[15:8] >= y)) ? S_CMP : S_DIV;
            end
         end
         S_DIV: begin
            if (p_shift >= {1'b0, y_q}) begin
               p_d            = p_shift - {1'b0, y_q};
               q_ex_d[step_q] = 1'b1;
            end else begin
               p_d = p_shift;
            end
            if (step_q == 3'd0) begin
               state_d = S_CMP;
            end else begin
               step_d = step_q - 3'd1;
            end
         end
         S_CMP: begin
            state_d = S_IDLE;
            if (skip_q) begin
               skip_acc_d = skip_acc_q + 16'd1;
            end else begin
               if ((q_app_q != q_ex_q) || (r_app_q != p_q[7:0])) begin
                  err_acc_d = err_acc_q + 16'd1;
               end
               sum_acc_d = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
               if (ed > max_acc_q) begin
                  max_acc_d = ed;
               end
            end
            if (idx_inc == WIN_W) begin
               // Publish totals that already include this sample, then restart.
               err_cnt_d   = err_acc_d;
               skip_cnt_d  = skip_acc_d;
               sum_ed_d    = sum_acc_d;
               max_ed_d    = max_acc_d;
               rpt_valid_d = 1'b1;
               idx_d       = 16'd0;
               err_acc_d   = 16'd0;
               skip_acc_d  = 16'd0;
               sum_acc_d   = '0;
               max_acc_d   = 8'd0;
            end else begin
               idx_d = idx_inc;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Clear overrides everything; the published report is left untouched.
      if (stat_clr) begin
         state_d     = S_IDLE;
         idx_d       = 16'd0;
         err_acc_d   = 16'd0;
         skip_acc_d  = 16'd0;
         sum_acc_d   = '0;
         max_acc_d   = 8'd0;
         rpt_valid_d = 1'b0;
         err_cnt_d   = err_cnt_q;
         skip_cnt_d  = skip_cnt_q;
         sum_ed_d    = sum_ed_q;
         max_ed_d    = max_ed_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         x_lo_q      <= 8'd0;
         y_q         <= 8'd0;
         q_app_q     <= 8'd0;
         r_app_q     <= 8'd0;
         p_q         <= 9'd0;
         q_ex_q      <= 8'd0;
         step_q      <= 3'd0;
         skip_q      <= 1'b0;
         idx_q       <= 16'd0;
         err_acc_q   <= 16'd0;
         skip_acc_q  <= 16'd0;
         sum_acc_q   <= '0;
         max_acc_q   <= 8'd0;
         rpt_valid_q <= 1'b0;
         err_cnt_q   <= 16'd0;
         skip_cnt_q  <= 16'd0;
         sum_ed_q    <= '0;
         max_ed_q    <= 8'd0;
      end else begin
         state_q     <= state_d;
         x_lo_q      <= x_lo_d;
         y_q         <= y_d;
         q_app_q     <= q_app_d;
         r_app_q     <= r_app_d;
         p_q         <= p_d;
         q_ex_q      <= q_ex_d;
         step_q      <= step_d;
         skip_q      <= skip_d;
         idx_q       <= idx_d;
         err_acc_q   <= err_acc_d;
         skip_acc_q  <= skip_acc_d;
         sum_acc_q   <= sum_acc_d;
         max_acc_q   <= max_acc_d;
         rpt_valid_q <= rpt_valid_d;
         err_cnt_q   <= err_cnt_d;
         skip_cnt_q  <= skip_cnt_d;
         sum_ed_q    <= sum_ed_d;
         max_ed_q    <= max_ed_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign rpt_valid = rpt_valid_q;
   assign err_cnt   = err_cnt_q;
   assign skip_cnt  = skip_cnt_q;
   assign sum_ed    = sum_ed_q;
   assign max_ed    = max_ed_q;

endmodule

// File: tb/tb_div_error_monitor.sv
// Directed bench for div_error_monitor. Four instances share the operand
// buses and clears, each with its own in_valid:
//   0: WIN=1, 1: WIN=2, 2: WIN=4, 3: ACC_W=8 WIN=2.
module tb_div_error_monitor;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stat_clr = 1'b0;
   logic [3:0]  in_valid = 4'd0;
   logic [15:0] x = 16'd0;
   logic [7:0]  y = 8'd0;
   logic [7:0]  q_app = 8'd0;
   logic [7:0]  r_app = 8'd0;

   logic [3:0]  rdy;
   logic [3:0]  rpt;
   logic [15:0] err_c  [4];
   logic [15:0] skip_c [4];
   logic [7:0]  max_c  [4];
   logic [23:0] sum_c  [3];
   logic [7:0]  sum8;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   div_error_monitor #(.WIN(1), .ACC_W(24)) u_w1 (
      .clk(clk), .rst_n(rst_n), .stat_clr(stat_clr), .in_valid(in_valid[0]), .in_ready(rdy[0]),
      .x(x), .y(y), .q_app(q_app), .r_app(r_app), .rpt_valid(rpt[0]),
      .err_cnt(err_c[0]), .skip_cnt(skip_c[0]), .sum_ed(sum_c[0]), .max_ed(max_c[0]));
   div_error_monitor #(.WIN(2), .ACC_W(24)) u_w2 (
      .clk(clk), .rst_n(rst_n), .stat_clr(stat_clr), .in_valid(in_valid[1]), .in_ready(rdy[1]),
      .x(x), .y(y), .q_app(q_app), .r_app(r_app), .rpt_valid(rpt[1]),
      .err_cnt(err_c[1]), .skip_cnt(skip_c[1]), .sum_ed(sum_c[1]), .max_ed(max_c[1]));
   div_error_monitor #(.WIN(4), .ACC_W(24)) u_w4 (
      .clk(clk), .rst_n(rst_n), .stat_clr(stat_clr), .in_valid(in_valid[2]), .in_ready(rdy[2]),
      .x(x), .y(y), .q_app(q_app), .r_app(r_app), .rpt_valid(rpt[2]),
      .err_cnt(err_c[2]), .skip_cnt(skip_c[2]), .sum_ed(sum_c[2]), .max_ed(max_c[2]));
   div_error_monitor #(.WIN(2), .ACC_W(8)) u_a8 (
      .clk(clk), .rst_n(rst_n), .stat_clr(stat_clr), .in_valid(in_valid[3]), .in_ready(rdy[3]),
      .x(x), .y(y), .q_app(q_app), .r_app(r_app), .rpt_valid(rpt[3]),
      .err_cnt(err_c[3]), .skip_cnt(skip_c[3]), .sum_ed(sum8), .max_ed(max_c[3]));

   // Waits (bounded) for in_ready, presents one sample and returns at the
   // falling edge right after the accept edge.
   task automatic send(input int k, input logic [15:0] xv, input logic [7:0] yv,
                       input logic [7:0] qa, input logic [7:0] ra);
      int n = 0;
      @(negedge clk);
      while (!rdy[k] && n < 50) begin
         @(negedge clk);
         n++;
      end
      tests_run++;
      if (rdy[k] !== 1'b1) begin
         tests_failed++;
         $display("FAIL ready_wait dut%0d: in_ready=%b required 1", k, rdy[k]);
      end
      x = xv; y = yv; q_app = qa; r_app = ra;
      in_valid[k] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid[k] = 1'b0;
      $display("[TB] dut%0d sample x=%h y=%h q_app=%0d r_app=%0d", k, xv, yv, qa, ra);
   endtask

   // Counts falling edges from the one after the accept edge (n=1) until rpt.
   task automatic wait_rpt(input int k, output int n);
      n = 1;
      while (!rpt[k] && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset();
      for (int k = 0; k < 4; k++) begin
         tests_run++;
         if (rdy[k] !== 1'b1 || rpt[k] !== 1'b0 || err_c[k] !== 16'd0 ||
             skip_c[k] !== 16'd0 || max_c[k] !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset dut%0d: rdy=%b rpt=%b err=%0d skip=%0d max=%0d required 1 0 0 0 0",
                     k, rdy[k], rpt[k], err_c[k], skip_c[k], max_c[k]);
         end
      end
      tests_run++;
      if (sum_c[0] !== 24'd0 || sum_c[1] !== 24'd0 || sum_c[2] !== 24'd0 || sum8 !== 8'd0) begin
         tests_failed++;
         $display("FAIL reset_sum: %0d %0d %0d %0d required 0", sum_c[0], sum_c[1], sum_c[2], sum8);
      end
   endtask

   task automatic test_exact_win1();
      int n;
      send(0, 16'h1234, 8'h56, 8'd54, 8'd16);
      tests_run++;
      if (rdy[0] !== 1'b0) begin
         tests_failed++;
         $display("FAIL busy_after_accept: in_ready=%b required 0", rdy[0]);
      end
      wait_rpt(0, n);
      tests_run++;
      if (n !== 10 || rdy[0] !== 1'b1) begin
         tests_failed++;
         $display("FAIL exact_latency: cycles=%0d rdy=%b required 10 1", n, rdy[0]);
      end
      tests_run++;
      if (err_c[0] !== 16'd0 || sum_c[0] !== 24'd0 || max_c[0] !== 8'd0 || skip_c[0] !== 16'd0) begin
         tests_failed++;
         $display("FAIL exact_report: err=%0d sum=%0d max=%0d skip=%0d required 0 0 0 0",
                  err_c[0], sum_c[0], max_c[0], skip_c[0]);
      end
      @(negedge clk);
      tests_run++;
      if (rpt[0] !== 1'b0) begin
         tests_failed++;
         $display("FAIL rpt_pulse_width: rpt_valid=%b required 0", rpt[0]);
      end
   endtask

   task automatic test_error_win1();
      int n;
      send(0, 16'h1234, 8'h56, 8'd50, 8'd16);
      wait_rpt(0, n);
      tests_run++;
      if (n !== 10 || err_c[0] !== 16'd1 || sum_c[0] !== 24'd4 || max_c[0] !== 8'd4) begin
         tests_failed++;
         $display("FAIL error_report: cycles=%0d err=%0d sum=%0d max=%0d required 10 1 4 4",
                  n, err_c[0], sum_c[0], max_c[0]);
      end
   endtask

   task automatic test_skip();
      int n;
      send(1, 16'h1234, 8'h00, 8'd7, 8'd7);
      tests_run++;
      if (rdy[1] !== 1'b0) begin
         tests_failed++;
         $display("FAIL skip_busy: in_ready=%b required 0", rdy[1]);
      end
      @(negedge clk);
      tests_run++;
      if (rdy[1] !== 1'b1 || rpt[1] !== 1'b0) begin
         tests_failed++;
         $display("FAIL skip_ready: rdy=%b rpt=%b required 1 0", rdy[1], rpt[1]);
      end
      send(1, 16'hFF00, 8'h80, 8'd1, 8'd1);
      wait_rpt(1, n);
      tests_run++;
      if (n !== 2 || skip_c[1] !== 16'd2 || err_c[1] !== 16'd0 || sum_c[1] !== 24'd0 || max_c[1] !== 8'd0) begin
         tests_failed++;
         $display("FAIL skip_report: cycles=%0d skip=%0d err=%0d sum=%0d max=%0d required 2 2 0 0 0",
                  n, skip_c[1], err_c[1], sum_c[1], max_c[1]);
      end
   endtask

   task automatic test_window4();
      int n;
      logic [7:0] qa_tab [4];
      qa_tab[0] = 8'd57; qa_tab[1] = 8'd54; qa_tab[2] = 8'd47; qa_tab[3] = 8'd55;
      for (int i = 0; i < 4; i++) send(2, 16'h1234, 8'h56, qa_tab[i], 8'd16);
      wait_rpt(2, n);
      tests_run++;
      if (n !== 10 || err_c[2] !== 16'd3 || sum_c[2] !== 24'd11 || max_c[2] !== 8'd7 || skip_c[2] !== 16'd0) begin
         tests_failed++;
         $display("FAIL win4_report: cycles=%0d err=%0d sum=%0d max=%0d skip=%0d required 10 3 11 7 0",
                  n, err_c[2], sum_c[2], max_c[2], skip_c[2]);
      end
      // Back-to-back exact window: accumulators must have restarted.
      for (int i = 0; i < 4; i++) send(2, 16'h1234, 8'h56, 8'd54, 8'd16);
      wait_rpt(2, n);
      tests_run++;
      if (n !== 10 || err_c[2] !== 16'd0 || sum_c[2] !== 24'd0 || max_c[2] !== 8'd0) begin
         tests_failed++;
         $display("FAIL win4_clean: cycles=%0d err=%0d sum=%0d max=%0d required 10 0 0 0",
                  n, err_c[2], sum_c[2], max_c[2]);
      end
   endtask

   task automatic test_saturate();
      int n;
      // 5/100 gives q_ex=0 r_ex=5, so q_app=200 is an error distance of 200.
      send(3, 16'h0005, 8'd100, 8'd200, 8'd5);
      send(3, 16'h0005, 8'd100, 8'd200, 8'd5);
      wait_rpt(3, n);
      tests_run++;
      if (sum8 !== 8'd255 || max_c[3] !== 8'd200 || err_c[3] !== 16'd2) begin
         tests_failed++;
         $display("FAIL saturate: sum=%0d max=%0d err=%0d required 255 200 2", sum8, max_c[3], err_c[3]);
      end
   endtask

   task automatic test_stat_clr_abort();
      int n;
      send(2, 16'h1234, 8'h56, 8'd60, 8'd16);
      repeat (3) @(negedge clk);
      stat_clr = 1'b1;
      @(negedge clk);
      stat_clr = 1'b0;
      tests_run++;
      if (rdy[2] !== 1'b1 || rpt[2] !== 1'b0) begin
         tests_failed++;
         $display("FAIL clr_abort_ready: rdy=%b rpt=%b required 1 0", rdy[2], rpt[2]);
      end
      tests_run++;
      if (err_c[2] !== 16'd0 || sum_c[2] !== 24'd0) begin
         tests_failed++;
         $display("FAIL clr_report_hold: err=%0d sum=%0d required 0 0", err_c[2], sum_c[2]);
      end
      send(2, 16'h1234, 8'h56, 8'd56, 8'd16);
      for (int i = 0; i < 3; i++) send(2, 16'h1234, 8'h56, 8'd54, 8'd16);
      wait_rpt(2, n);
      tests_run++;
      if (n !== 10 || err_c[2] !== 16'd1 || sum_c[2] !== 24'd2 || max_c[2] !== 8'd2) begin
         tests_failed++;
         $display("FAIL clr_excluded: cycles=%0d err=%0d sum=%0d max=%0d required 10 1 2 2",
                  n, err_c[2], sum_c[2], max_c[2]);
      end
   endtask

   task automatic test_reset_abort();
      int n;
      send(0, 16'h1234, 8'h56, 8'd50, 8'd16);
      repeat (4) @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      tests_run++;
      if (err_c[0] !== 16'd0 || sum_c[0] !== 24'd0 || max_c[0] !== 8'd0 || rpt[0] !== 1'b0 || err_c[2] !== 16'd0) begin
         tests_failed++;
         $display("FAIL reset_abort_outputs: err=%0d sum=%0d max=%0d rpt=%b err2=%0d required 0",
                  err_c[0], sum_c[0], max_c[0], rpt[0], err_c[2]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      tests_run++;
      if (rdy[0] !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_abort_ready: in_ready=%b required 1", rdy[0]);
      end
      send(0, 16'h1234, 8'h56, 8'd54, 8'd16);
      wait_rpt(0, n);
      tests_run++;
      if (n !== 10 || err_c[0] !== 16'd0 || sum_c[0] !== 24'd0) begin
         tests_failed++;
         $display("FAIL reset_abort_next: cycles=%0d err=%0d sum=%0d required 10 0 0", n, err_c[0], sum_c[0]);
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_exact_win1();
      test_error_win1();
      test_skip();
      test_window4();
      test_saturate();
      test_stat_clr_abort();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
